// File: rtl/staircase_pkg.sv
// Shared types and helpers for the thermometer staircase monitor.
package staircase_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 4;
    localparam int IDX_W     = $clog2(DEF_WIDTH + 1);

    // A thermometer code has all its ones packed from the LSB, so adding one
    // carries through every set bit and leaves no overlap with the original.
    function automatic logic is_thermo(input logic [31:0] code);
        return (code & (code + 32'd1)) == 32'd0;
    endfunction

    // Number of ones; for a valid thermometer code this is the step index.
    function automatic int therm_popcount(input logic [31:0] code);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if (code[i]) n++;
        end
        return n;
    endfunction

    // Staircase wraps from the all-ones step back to zero.
    function automatic int next_step(input int exp, input int width);
        return (exp == width) ? 0 : exp + 1;
    endfunction

endpackage

// File: rtl/staircase_thermo_decoder_thermo_to_bin.sv
// Combinational thermometer-to-binary decoder with validity flag.
module thermo_to_bin
    import staircase_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SIW   = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] therm_in,
    output logic             valid,
    output logic [SIW-1:0]   step
);

    logic [31:0] code_ext;

    // Zero-extend the tap code to the width the helper functions work on.
    for (genvar gi = 0; gi < 32; gi++) begin : g_ext
        if (gi < WIDTH) begin : g_bit
            assign code_ext[gi] = therm_in[gi];
        end else begin : g_pad
            assign code_ext[gi] = 1'b0;
        end
    end

    assign valid = is_thermo(code_ext);
    assign step  = SIW'(therm_popcount(code_ext));

endmodule

// File: rtl/staircase_thermo_decoder.sv
// Receive-side staircase monitor: sample, decode, order check, lock and error count.
module staircase_thermo_decoder
    import staircase_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int LOCK_COUNT = 2,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             therm_in,
    input  logic                         sample_en,
    output logic [$clog2(WIDTH+1)-1:0]   step_idx,
    output logic                         step_valid,
    output logic                         period_done,
    output logic                         locked,
    output logic                         err_bubble,
    output logic                         err_seq,
    output logic [ERR_CNT_W-1:0]         err_count
);

    localparam int SIW = $clog2(WIDTH + 1);
    localparam int PW  = $clog2(LOCK_COUNT + 1);

    // Stage 1: raw sample
    logic             s1_en_reg;
    logic [WIDTH-1:0] s1_code_reg;

    // Decoder view of the stage-1 code
    logic             dec_valid;
    logic [SIW-1:0]   dec_step;

    // Tracking state
    state_t           state_reg, state_next;
    logic [SIW-1:0]   exp_reg, exp_next;
    logic [PW-1:0]    periods_reg, periods_next;

    // Stage 2: registered outputs
    logic [SIW-1:0]       step_idx_reg, step_idx_next;
    logic                 step_valid_reg, step_valid_next;
    logic                 period_done_reg, period_done_next;
    logic                 locked_reg, locked_next;
    logic                 err_bubble_reg, err_bubble_next;
    logic                 err_seq_reg, err_seq_next;
    logic [ERR_CNT_W-1:0] err_count_reg, err_count_next;

    thermo_to_bin #(
        .WIDTH (WIDTH),
        .SIW   (SIW)
    ) u_dec (
        .therm_in (s1_code_reg),
        .valid    (dec_valid),
        .step     (dec_step)
    );

    // Stage-1 capture; a reset drops any sample in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_en_reg   <= 1'b0;
            s1_code_reg <= '0;
        end else begin
            s1_en_reg   <= sample_en;
            s1_code_reg <= therm_in;
        end
    end

    // Next-state and output decisions, only acting on cycles that carry a sample.
    always_comb begin
        state_next       = state_reg;
        exp_next         = exp_reg;
        periods_next     = periods_reg;
        step_idx_next    = step_idx_reg;
        step_valid_next  = 1'b0;
        period_done_next = 1'b0;
        locked_next      = locked_reg;
        err_bubble_next  = 1'b0;
        err_seq_next     = 1'b0;
        err_count_next   = err_count_reg;

        if (s1_en_reg) begin
            if (!dec_valid) begin
                // A bubble outranks any ordering check and keeps the old step.
                err_bubble_next = 1'b1;
                state_next      = SEARCH;
                locked_next     = 1'b0;
            end else begin
                step_idx_next   = dec_step;
                step_valid_next = 1'b1;
                if (state_reg == SEARCH) begin
                    // Only the bottom of the staircase gives a reference point.
                    if (dec_step == '0) begin
                        state_next   = TRACK;
                        exp_next     = SIW'(1);
                        periods_next = '0;
                    end
                end else if (dec_step == exp_reg) begin
                    exp_next = SIW'(next_step(int'(exp_reg), WIDTH));
                    if (dec_step == '0) begin
                        // Zero is only expected right after the all-ones step.
                        period_done_next = 1'b1;
                        if (state_reg == TRACK) begin
                            if (int'(periods_reg) + 1 >= LOCK_COUNT) begin
                                state_next  = LOCKED;
                                locked_next = 1'b1;
                            end else begin
                                periods_next = periods_reg + PW'(1);
                            end
                        end
                    end
                end else begin
                    err_seq_next = 1'b1;
                    state_next   = SEARCH;
                    locked_next  = 1'b0;
                end
            end

            if ((err_bubble_next || err_seq_next) && (err_count_reg != '1)) begin
                err_count_next = err_count_reg + ERR_CNT_W'(1);
            end
        end
    end

    // State and stage-2 output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= SEARCH;
            exp_reg         <= '0;
            periods_reg     <= '0;
            step_idx_reg    <= '0;
            step_valid_reg  <= 1'b0;
            period_done_reg <= 1'b0;
            locked_reg      <= 1'b0;
            err_bubble_reg  <= 1'b0;
            err_seq_reg     <= 1'b0;
            err_count_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            exp_reg         <= exp_next;
            periods_reg     <= periods_next;
            step_idx_reg    <= step_idx_next;
            step_valid_reg  <= step_valid_next;
            period_done_reg <= period_done_next;
            locked_reg      <= locked_next;
            err_bubble_reg  <= err_bubble_next;
            err_seq_reg     <= err_seq_next;
            err_count_reg   <= err_count_next;
        end
    end

    assign step_idx    = step_idx_reg;
    assign step_valid  = step_valid_reg;
    assign period_done = period_done_reg;
    assign locked      = locked_reg;
    assign err_bubble  = err_bubble_reg;
    assign err_seq     = err_seq_reg;
    assign err_count   = err_count_reg;

endmodule
